cla_add32_pipe: RTL and testbench

- Two-stage pipelined 32-bit add/subtract unit built from two instances of the existing 16-bit carry-lookahead slice (cla_16bits).
- Stage 1 adds the low halfword and registers its carry. Stage 2 adds the high halfword using that registered carry.
- Valid/ready handshake on both sides; sits between the ALU operand-decode stage and the ALU result/flag writeback.

---
 rtl/cla_add32_pipe.sv | 176 +++++++++++++++++
 tb/tb_cla_add32_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_add32_pipe.sv
// ---------------------------------------------------------------------------
// cla_16bits: 16-bit carry-lookahead adder slice.
//   a, b : addends        ci : carry in
//   s    : sum            co : carry out of bit 15
// Four 4-bit lookahead groups plus a second-level lookahead across the groups,
// so no carry ripples between bits or between groups.
// ---------------------------------------------------------------------------
module cla_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);

    // Expanded 4-bit lookahead: returns carries into positions 1..4.
    function automatic logic [4:1] la4(input logic [3:0] g, input logic [3:0] p, input logic c);
        logic [4:1] r;
        r[1] = g[0] | (p[0] & c);
        r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        r[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c);
        return r;
    endfunction

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] carry;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;
    logic [4:1]  gc;
    logic [4:1]  cc;

    // Group generate/propagate, group carries, then in-group carries
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        carry = '0;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        gc    = '0;
        cc    = '0;
        for (int k = 0; k < 4; k++) begin
            gc       = la4(g[4*k +: 4], p[4*k +: 4], 1'b0);
            grp_g[k] = gc[4];
            grp_p[k] = &p[4*k +: 4];
        end
        grp_c[0]   = ci;
        grp_c[4:1] = la4(grp_g, grp_p, ci);
        for (int k = 0; k < 4; k++) begin
            cc                 = la4(g[4*k +: 4], p[4*k +: 4], grp_c[k]);
            carry[4*k]         = grp_c[k];
            carry[4*k + 1 +: 3] = cc[3:1];
        end
        s  = p ^ carry;
        co = grp_c[4];
    end

endmodule

// ---------------------------------------------------------------------------
// cla_add32_pipe: two-stage pipelined 32-bit add/subtract unit.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand beat handshake (in_ready is combinational)
//   a, b, op, cin       : operands; op 00 ADD, 01 SUB, 10 ADC, 11 SBB
//   out_valid/out_ready : result handshake
//   s, co, ov, zero     : registered sum, carry out, signed overflow, zero flag
// Stage 1 adds the low halfword and registers its carry together with the
// high operand halves; stage 2 adds the high halfword into the result register.
// Only WIDTH = 32 is supported (two fixed 16-bit slices).
// ---------------------------------------------------------------------------
module cla_add32_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HALF  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             zero
);

    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [HALF-1:0]  s_lo_c;
    logic             c16_c;
    logic [HALF-1:0]  s_hi_c;
    logic             co_hi_c;

    logic             s1_valid;
    logic [HALF-1:0]  s_lo_q;
    logic             c16_q;
    logic [HALF-1:0]  a_hi_q;
    logic [HALF-1:0]  bx_hi_q;

    logic             s1_adv;
    logic             s1_load;
    logic             out_load;

    // Subtract is a + ~b + 1; the carry-in variants take cin instead of the constant
    assign bx = op[0] ? ~b : b;
    assign c0 = op[1] ? cin : op[0];

    // Handshake: each stage advances when the stage ahead is empty or draining
    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;
    assign s1_load  = in_valid && in_ready;
    assign out_load = s1_valid && s1_adv;

    cla_16bits u_lo (
        .a  (a[HALF-1:0]),
        .b  (bx[HALF-1:0]),
        .ci (c0),
        .s  (s_lo_c),
        .co (c16_c)
    );

    cla_16bits u_hi (
        .a  (a_hi_q),
        .b  (bx_hi_q),
        .ci (c16_q),
        .s  (s_hi_c),
        .co (co_hi_c)
    );

    // Stage 1: low-half sum, slice carry and high operand halves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s_lo_q   <= '0;
            c16_q    <= 1'b0;
            a_hi_q   <= '0;
            bx_hi_q  <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s_lo_q   <= s_lo_c;
            c16_q    <= c16_c;
            a_hi_q   <= a[WIDTH-1:HALF];
            bx_hi_q  <= bx[WIDTH-1:HALF];
        end else if (out_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register; a load with out_ready high replaces without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
            ov        <= 1'b0;
            zero      <= 1'b0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            s         <= {s_hi_c, s_lo_q};
            co        <= co_hi_c;
            ov        <= (a_hi_q[HALF-1] == bx_hi_q[HALF-1]) && (s_hi_c[HALF-1] != a_hi_q[HALF-1]);
            zero      <= ~|{s_hi_c, s_lo_q};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla_add32_pipe.sv
// Testbench for cla_add32_pipe: constant vector table, latency, backpressure
// stream and mid-flight reset, with a FIFO scoreboard of expected results.
module tb_cla_add32_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        zero;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        zero;

    int n_vec = 0;
    int n_bad = 0;
    vec_t sb[$];

    cla_add32_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ov        (ov),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop,
                                input logic vcin, input logic [31:0] vs, input logic vco,
                                input logic vov, input logic vz);
        vec_t t;
        t.a = va; t.b = vb; t.op = vop; t.cin = vcin;
        t.s = vs; t.co = vco; t.ov = vov; t.zero = vz;
        return t;
    endfunction

    // Reference: plain 33-bit addition of the prepared operands
    function automatic vec_t model(input logic [31:0] va, input logic [31:0] vb,
                                   input logic [1:0] vop, input logic vcin);
        vec_t t;
        logic [31:0] bx;
        logic        c0;
        logic [32:0] sum;
        bx  = vop[0] ? ~vb : vb;
        c0  = vop[1] ? vcin : vop[0];
        sum = 33'(va) + 33'(bx) + 33'(c0);
        t.a = va; t.b = vb; t.op = vop; t.cin = vcin;
        t.s    = sum[31:0];
        t.co   = sum[32];
        t.ov   = (va[31] == bx[31]) && (sum[31] != va[31]);
        t.zero = (sum[31:0] == 32'h0);
        return t;
    endfunction

    // One clock cycle: drive at posedge+1, observe the handshake at the negedge
    task automatic step(input logic v, input vec_t t, input logic ordy,
                        output logic acc, output logic ovld);
        in_valid  = v;
        a         = t.a;
        b         = t.b;
        op        = t.op;
        cin       = t.cin;
        out_ready = ordy;
        @(negedge clk);
        acc  = v && in_ready;
        ovld = out_valid;
        if (acc) sb.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        vec_t idle;
        logic acc;
        logic ovld;
        int   cyc;
        idle = mk(32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            step(1'b0, idle, 1'b1, acc, ovld);
            cyc++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: scoreboard pop on each transfer, stability while stalled
    logic        prev_hold = 1'b0;
    logic [34:0] prev_out  = '0;

    always @(negedge clk) begin
        vec_t e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                chk("hold_stable", 64'({out_valid, s, co, ov, zero}), 64'({1'b1, prev_out}));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'({s, co, ov, zero}), 64'({e.s, e.co, e.ov, e.zero}));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {s, co, ov, zero};
        end
    end

    vec_t tbl[12];

    initial begin
        vec_t t;
        vec_t idle;
        logic acc;
        logic ovld;
        logic saw_block;
        int   idx;
        int   cyc;

        tbl[0]  = mk(32'h0000_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(32'h0000_0005, 32'h0000_0005, 2'b01, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tbl[2]  = mk(32'h0000_0000, 32'h0000_0001, 2'b01, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        tbl[4]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tbl[5]  = mk(32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tbl[6]  = mk(32'h0000_000A, 32'h0000_0003, 2'b11, 1'b0, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
        tbl[7]  = mk(32'h0000_0001, 32'h0000_0002, 2'b00, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        tbl[9]  = mk(32'h0000_0003, 32'h0000_0001, 2'b01, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(32'h0000_FFFF, 32'h0000_0000, 2'b10, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(32'h8000_0000, 32'h8000_0000, 2'b00, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        idle = mk(32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({out_valid, s, co, ov, zero, in_ready}), 64'({1'b0, 32'h0, 3'b000, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors streamed back to back; each must be taken on its first cycle
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i], 1'b1, acc, ovld);
            chk("tbl_accept", 64'(acc), 64'd1);
            cyc = 0;
            while (!acc && cyc < 10) begin
                step(1'b1, tbl[i], 1'b1, acc, ovld);
                cyc++;
            end
        end
        drain();

        // Latency: accepted in cycle N, valid in N+2 and not N+1
        step(1'b1, tbl[0], 1'b1, acc, ovld);
        chk("lat_accept", 64'(acc), 64'd1);
        step(1'b0, idle, 1'b1, acc, ovld);
        chk("lat_n_plus_1", 64'(ovld), 64'd0);
        step(1'b0, idle, 1'b1, acc, ovld);
        chk("lat_n_plus_2", 64'(ovld), 64'd1);
        drain();

        // 8-beat stream with out_ready low for cycles 3..6
        saw_block = 1'b0;
        idx = 0;
        cyc = 0;
        t = model($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        while (idx < 8 && cyc < 60) begin
            step(1'b1, t, !(cyc >= 3 && cyc <= 6), acc, ovld);
            if (!acc) begin
                if (!saw_block) chk("held_beats", 64'(sb.size()), 64'd2);
                saw_block = 1'b1;
            end else begin
                idx++;
                t = model($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            cyc++;
        end
        chk("stream_all_sent", 64'(idx), 64'd8);
        chk("in_ready_fell", 64'(saw_block), 64'd1);
        drain();

        // Reset with two beats in flight
        step(1'b1, model(32'h1234_5678, 32'h1111_1111, 2'b00, 1'b0), 1'b0, acc, ovld);
        step(1'b1, model(32'h0000_0010, 32'h0000_0001, 2'b01, 1'b0), 1'b0, acc, ovld);
        chk("inflight_valid", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({out_valid, s, co, ov, zero}), 64'({1'b0, 32'h0, 3'b000}));
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
        step(1'b1, model(32'hCAFE_0001, 32'h0000_FFFF, 2'b00, 1'b0), 1'b1, acc, ovld);
        chk("post_reset_accept", 64'(acc), 64'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
